rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 data mux among four requesters (A, B, C, D).
- Drives the mux select pair (s0, s1) and a one-hot grant vector, and presents the registered mux output to a single downstream consumer.
- Sits directly in front of the structural 4:1 mux and sequences which source owns it, cycle by cycle.

---
 rtl/rr_mux4_arbiter_pkg.sv | 45 ++++
 rtl/rr_mux4_arbiter_mux4_bus.sv | 27 ++
 rtl/rr_mux4_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the rr_mux4_arbiter slice: FSM states, source
// indices, the default hold limit and the round-robin search helper.
package rr_mux4_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Source index as presented on {s0, s1}
  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int HOLD_CNT_W       = 8;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit of req searching upward from start, wrapping 3 -> 0.
  // Walking the offsets downward lets the closest candidate win last.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] start);
    pick_t      p;
    logic [1:0] cand;
    p.found = 1'b0;
    p.idx   = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4_bus.sv
// Parameterised-width 4:1 data mux; select index is {s0, s1}.
module mux4_bus
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         s0,
  input  logic         s1,
  output logic [W-1:0] y
);

  // Plain combinational select of one of the four buses
  always_comb begin
    y = a;
    unique case ({s0, s1})
      IDX_A: y = a;
      IDX_B: y = b;
      IDX_C: y = c;
      IDX_D: y = d;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 data mux for sources A..D.
// Grant, select and data outputs are all registered; dout trails gnt by
// one cycle. Optional macro RR_MUX4_HOLD_LIMIT_EN adds a hold counter that
// forces rotation after MAX_HOLD consecutive grant cycles when another
// source is waiting.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] din_c,
  input  logic [DATA_W-1:0] din_d,
  output logic [3:0]        gnt,
  output logic              s0,
  output logic              s1,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;

  logic [1:0]        owner_idx;
  logic [3:0]        others;
  pick_t             pick_idle;
  pick_t             pick_next;
  logic              rotate;
  logic [DATA_W-1:0] mux_y;

  assign owner_idx = {s0_q, s1_q};
  assign others    = req & ~idx_to_onehot(owner_idx);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_next = rr_pick(others, owner_idx + 2'd1);

`ifdef RR_MUX4_HOLD_LIMIT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  hold_expired;

  // Counter reaching HOLD_LAST means the owner is in its MAX_HOLD-th cycle
  assign hold_expired = (hold_cnt_q >= HOLD_LAST) && (|others);
  assign rotate       = ~req[owner_idx] | hold_expired;

  // Hold counter clears on any grant change, otherwise counts BUSY cycles and saturates
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE || rotate) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q < HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic [7:0] unused_max_hold;

  // Without the limit the owner only leaves when it drops its request
  assign rotate          = ~req[owner_idx];
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // Arbitration: choose the next owner, selects and pointer for the coming cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_idle.found) begin
          state_d      = BUSY;
          gnt_d        = idx_to_onehot(pick_idle.idx);
          {s0_d, s1_d} = pick_idle.idx;
          ptr_d        = pick_idle.idx + 2'd1;
        end
      end
      BUSY: begin
        if (rotate) begin
          if (pick_next.found) begin
            gnt_d        = idx_to_onehot(pick_next.idx);
            {s0_d, s1_d} = pick_next.idx;
            ptr_d        = pick_next.idx + 2'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
    endcase
  end

  // Data path: capture the selected source whenever someone held the grant this cycle
  always_comb begin
    dout_vld_d = |gnt_q;
    dout_d     = dout_q;
    if (|gnt_q) begin
      dout_d = mux_y;
    end
  end

  // All arbiter and data registers, cleared together by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_A;
      gnt_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  mux4_bus #(
    .W (DATA_W)
  ) u_mux (
    .a  (din_a),
    .b  (din_b),
    .c  (din_c),
    .d  (din_d),
    .s0 (s0_q),
    .s1 (s1_q),
    .y  (mux_y)
  );

  assign gnt      = gnt_q;
  assign s0       = s0_q;
  assign s1       = s1_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter (default build, no hold limit).
// A reference model tracks the owner as an integer and pushes the expected
// post-edge outputs; a monitor pops one entry per cycle and compares.
module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din_a, din_b, din_c, din_d;
  logic [3:0] gnt;
  logic       s0, s1;
  logic [7:0] dout;
  logic       dout_vld;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       chk_sel;
    logic       vld;
    logic [7:0] dout;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner = -1 means nobody holds the mux
  int         m_owner = -1;
  int         m_ptr   = 0;
  logic [7:0] m_dout  = 8'h00;

  rr_mux4_arbiter #(
    .DATA_W   (8),
    .MAX_HOLD (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din_a    (din_a),
    .din_b    (din_b),
    .din_c    (din_c),
    .din_d    (din_d),
    .gnt      (gnt),
    .s0       (s0),
    .s1       (s1),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("gnt", 32'(gnt), 32'(e.gnt));
    compareField("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    compareField("dout_vld", 32'(dout_vld), 32'(e.vld));
    compareField("dout", 32'(dout), 32'(e.dout));
    if (e.chk_sel) compareField("sel", 32'({s0, s1}), 32'(e.sel));
  endtask

  // Drive one cycle of inputs at the falling edge and push what the model expects after the next rising edge
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] data);
    logic [7:0] d[4];
    exp_t       e;
    int         nxt;
    @(negedge clk);
    d[0] = data[7:0];
    d[1] = data[15:8];
    d[2] = data[23:16];
    d[3] = data[31:24];
    rst   = r;
    req   = rq;
    din_a = d[0];
    din_b = d[1];
    din_c = d[2];
    din_d = d[3];
    if (r) begin
      e.gnt = 4'b0; e.sel = 2'd0; e.chk_sel = 1'b1; e.vld = 1'b0; e.dout = 8'h00;
      m_owner = -1;
      m_ptr   = 0;
      m_dout  = 8'h00;
    end else begin
      e.vld  = (m_owner >= 0);
      e.dout = (m_owner >= 0) ? d[m_owner] : m_dout;
      nxt = -1;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++)
          if (nxt < 0 && rq[(m_ptr + k) % 4]) nxt = (m_ptr + k) % 4;
      end else if (rq[m_owner]) begin
        nxt = m_owner;
      end else begin
        for (int k = 1; k < 4; k++)
          if (nxt < 0 && rq[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
      end
      if (nxt >= 0 && nxt != m_owner) m_ptr = (nxt + 1) % 4;
      e.gnt     = (nxt >= 0) ? (4'b0001 << nxt) : 4'b0000;
      e.sel     = (nxt >= 0) ? 2'(nxt) : 2'd0;
      e.chk_sel = (nxt >= 0);
      m_owner   = nxt;
      m_dout    = e.dout;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic [3:0] rq;
    int         waited;
    rst = 1'b1; req = 4'b0; din_a = 0; din_b = 0; din_c = 0; din_d = 0;

    // Reset with everyone requesting, then first grant goes to A
    applyStimulus(1'b1, 4'b1111, $urandom());
    applyStimulus(1'b1, 4'b1111, $urandom());
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, $urandom());

    // Rotation: each owner drops for one cycle after holding a few cycles
    for (int o = 0; o < 5; o++) begin
      applyStimulus(1'b0, 4'b1111, $urandom());
      applyStimulus(1'b0, 4'b1111, $urandom());
      applyStimulus(1'b0, 4'b1111 & ~(4'b0001 << (o % 4)), $urandom());
    end

    // Single requester C with known data
    applyStimulus(1'b1, 4'b0000, $urandom());
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0100, 32'h11_5A_22_33);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, $urandom());

    // Fairness: A releases while D waits, A re-raises and must wait for D
    applyStimulus(1'b1, 4'b0000, $urandom());
    applyStimulus(1'b0, 4'b0001, $urandom());
    applyStimulus(1'b0, 4'b1001, $urandom());
    applyStimulus(1'b0, 4'b1000, $urandom());
    applyStimulus(1'b0, 4'b1001, $urandom());
    applyStimulus(1'b0, 4'b1001, $urandom());
    applyStimulus(1'b0, 4'b0001, $urandom());
    applyStimulus(1'b0, 4'b0001, $urandom());

    // Reset mid-grant with B owning, then A wins on a fresh pointer
    applyStimulus(1'b1, 4'b0000, $urandom());
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0010, $urandom());
    applyStimulus(1'b1, 4'b0010, $urandom());
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0011, $urandom());

    // Random traffic: sticky requests with occasional resets
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      applyStimulus(($urandom_range(63) == 0), rq, $urandom());
    end

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
